prefix_16: RTL and testbench

PREFIX_16 -- requirements
Module: prefix_16

---
 rtl/prefix_16.sv | 108 ++++++++++
 tb/tb_prefix_16.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_16.sv
// Three-stage pipelined Kogge-Stone adder computing {cout, s} = x + y + c.
// Define PREFIX_16_OVF_EN to add the registered signed-overflow output ovf.
module prefix_16 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PREFIX_16_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L = $clog2(WIDTH);
    localparam int H = (L + 1) / 2;

    // Stage 1: bitwise propagate/generate. These two vectors carry all the
    // information the sum needs, so the raw operands are not kept separately.
    logic [WIDTH-1:0] p1_q, g1_q;
    logic             c1_q;

    // NOTE: non-blocking assignments make every stage read the pre-edge values of the one before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q <= '0;
            g1_q <= '0;
            c1_q <= 1'b0;
        end else begin
            p1_q <= x ^ y;
            g1_q <= x & y;
            c1_q <= c;
        end
    end

    // Group generate/propagate after each prefix level. The carry-in is folded
    // into bit 0, so gn[L][i] is the carry out of bit i.
    logic [WIDTH-1:0] gn [0:L];
    logic [WIDTH-1:0] pn [0:L-1];

    logic [WIDTH-1:0] g2_q, p2_q, pb2_q;
    logic             c2_q;

    assign gn[0] = {g1_q[WIDTH-1:1], g1_q[0] | (p1_q[0] & c1_q)};
    assign pn[0] = p1_q;

    for (genvar k = 1; k <= L; k++) begin : g_level
        localparam int D = 1 << (k - 1);
        logic [WIDTH-1:0] gin, pin;

        // The first level after the stage-2 register restarts from it.
        if (k == H + 1) begin : g_from_reg
            assign gin = g2_q;
            assign pin = p2_q;
        end else begin : g_from_comb
            assign gin = gn[k-1];
            assign pin = pn[k-1];
        end

        assign gn[k] = gin | (pin & (gin << D));

        if (k < L) begin : g_prop
            assign pn[k] = pin & (pin << D);
        end
    end

    // Stage 2: result of levels 1..H, plus the bitwise propagate for the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g2_q  <= '0;
            p2_q  <= '0;
            pb2_q <= '0;
            c2_q  <= 1'b0;
        end else begin
            g2_q  <= gn[H];
            p2_q  <= pn[H];
            pb2_q <= p1_q;
            c2_q  <= c1_q;
        end
    end

    // Stage 3: remaining levels, then sum bits from propagate XOR carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= pb2_q ^ {gn[L][WIDTH-2:0], c2_q};
            cout <= gn[L][WIDTH-1];
        end
    end

`ifdef PREFIX_16_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= gn[L][WIDTH-1] ^ gn[L][WIDTH-2];
        end
    end
`endif

endmodule

// File: tb/tb_prefix_16.sv
// Directed and random bench for prefix_16 at WIDTH=32.
// Define PREFIX_16_OVF_EN to also exercise the overflow output.
module tb_prefix_16;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] x     = '0;
    logic [W-1:0] y     = '0;
    logic         c     = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic [W+1:0] obs;

    int total = 0;
    int bad   = 0;

`ifdef PREFIX_16_OVF_EN
    logic ovf;
    assign obs = {ovf, cout, s};
`else
    assign obs = {1'b0, cout, s};
`endif

    prefix_16 #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (x),
        .y    (y),
        .c    (c),
        .s    (s),
        .cout (cout)
`ifdef PREFIX_16_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        x = a;
        y = b;
        c = ci;
    endtask

    task automatic flush;
        drive('0, '0, 1'b0);
        repeat (3) tick;
    endtask

    // Reference: {ovf, cout, s} from plain integer addition.
    function automatic logic [W+1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci);
        logic [W:0]   full;
        logic [W-1:0] low;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, ci};
        return {full[W] ^ low[W-1], full};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        drive(32'h1234, 32'h5678, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h want 0", i, obs);
            end
        end
        rst_n = 1'b1;
        drive(32'd100, 32'd200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            drive('0, '0, 1'b0);
            total++;
            if (obs[W:0] !== ((i == 2) ? 33'd300 : 33'd0)) begin
                bad++;
                $display("FAIL reset_release[%0d]: got %h want %h", i, obs[W:0],
                         (i == 2) ? 33'd300 : 33'd0);
            end
        end
        flush;
    endtask

    task automatic test_basic;
        drive(32'd10, 32'd20, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick;
            drive('0, '0, 1'b0);
            total++;
            if (obs[W:0] !== ((i == 2) ? 33'd31 : 33'd0)) begin
                bad++;
                $display("FAIL basic[%0d]: got %h want %h", i, obs[W:0],
                         (i == 2) ? 33'd31 : 33'd0);
            end
        end
        flush;
    endtask

    task automatic test_stream;
        logic [W-1:0] xs [5] = '{32'd25, 32'd52, 32'd5, 32'd70, 32'd15};
        logic [W-1:0] ys [5] = '{32'd30, 32'd60, 32'd9, 32'd90, 32'd37};
        logic         cs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W:0]   ex [5] = '{33'd56, 33'd113, 33'd14, 33'd160, 33'd53};
        logic [W:0]   want;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(xs[i], ys[i], cs[i]);
            else       drive('0, '0, 1'b0);
            tick;
            want = (i >= 2) ? ex[i-2] : '0;
            total++;
            if (obs[W:0] !== want) begin
                bad++;
                $display("FAIL stream[%0d]: got %h want %h", i, obs[W:0], want);
            end
        end
        flush;
    endtask

    task automatic test_back_to_back;
        logic [W:0] ex [4] = '{33'h0_2143_6588, 33'h0_2143_6588, 33'h0_2143_6588, 33'd7};
        logic [W:0] want;
        for (int i = 0; i < 6; i++) begin
            if (i < 3)       drive(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
            else if (i == 3) drive(32'd3, 32'd4, 1'b0);
            else             drive('0, '0, 1'b0);
            tick;
            want = (i >= 2) ? ex[i-2] : '0;
            total++;
            if (obs[W:0] !== want) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, obs[W:0], want);
            end
        end
        flush;
    endtask

    task automatic test_boundary;
        logic [W-1:0] xs [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA,
                                 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] ys [6] = '{32'h0, 32'hFFFF_FFFF, 32'h5555_5555,
                                 32'h0, 32'h1, 32'h8000_0000};
        logic         cs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W:0]   ex [6] = '{33'h1_0000_0000, 33'h1_FFFF_FFFF, 33'h1_0000_0000,
                                 33'h0_0000_0001, 33'h1_0000_0000, 33'h1_0000_0000};
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(xs[i], ys[i], cs[i]);
            else       drive('0, '0, 1'b0);
            tick;
            if (i >= 2) begin
                total++;
                if (obs[W:0] !== ex[i-2]) begin
                    bad++;
                    $display("FAIL boundary[%0d]: got %h want %h", i - 2, obs[W:0], ex[i-2]);
                end
            end
        end
        flush;
    endtask

    task automatic test_reset_midflight;
        drive(32'd1, 32'd2, 1'b0);
        tick;
        drive(32'd3, 32'd4, 1'b0);
        tick;
        drive(32'd5, 32'd6, 1'b0);
        tick;
        total++;
        if (obs[W:0] !== 33'd3) begin
            bad++;
            $display("FAIL midflight_pre: got %h want %h", obs[W:0], 33'd3);
        end
        rst_n = 1'b0;
        drive(32'd7, 32'd8, 1'b1);
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL midflight_async: got %h want 0", obs);
        end
        tick;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL midflight_held: got %h want 0", obs);
        end
        rst_n = 1'b1;
        drive(32'd40, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            drive('0, '0, 1'b0);
            total++;
            if (obs[W:0] !== ((i == 2) ? 33'd42 : 33'd0)) begin
                bad++;
                $display("FAIL midflight_after[%0d]: got %h want %h", i, obs[W:0],
                         (i == 2) ? 33'd42 : 33'd0);
            end
        end
        flush;
    endtask

`ifdef PREFIX_16_OVF_EN
    task automatic test_ovf;
        logic [W-1:0] xs [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF};
        logic [W-1:0] ys [4] = '{32'h0, 32'h8000_0000, 32'h1, 32'h1};
        logic         cs [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [W+1:0] ex [4] = '{34'h2_8000_0000, 34'h3_0000_0000,
                                 34'h0_0000_0002, 34'h1_0000_0000};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(xs[i], ys[i], cs[i]);
            else       drive('0, '0, 1'b0);
            tick;
            if (i >= 2) begin
                total++;
                if (obs !== ex[i-2]) begin
                    bad++;
                    $display("FAIL ovf[%0d]: got %h want %h", i - 2, obs, ex[i-2]);
                end
            end
        end
        flush;
    endtask
`endif

    task automatic test_random;
        logic [W+1:0] q [$];
        logic [W+1:0] want;
        logic [W-1:0] a, b;
        logic         ci;
        for (int i = 0; i < 10002; i++) begin
            if (i < 10000) begin
                a  = $urandom;
                b  = $urandom;
                ci = 1'($urandom_range(0, 1));
            end else begin
                a  = '0;
                b  = '0;
                ci = 1'b0;
            end
            drive(a, b, ci);
            q.push_back(ref_sum(a, b, ci));
            tick;
            if (q.size() == 3) begin
                want = q.pop_front();
`ifndef PREFIX_16_OVF_EN
                want[W+1] = 1'b0;
`endif
                total++;
                if (obs !== want) begin
                    bad++;
                    $display("FAIL random[%0d]: got %h want %h", i - 2, obs, want);
                end
            end
        end
        flush;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stream;
        test_back_to_back;
        test_boundary;
        test_reset_midflight;
`ifdef PREFIX_16_OVF_EN
        test_ovf;
`endif
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
